// File: rtl/leaf_stream_packetizer.sv
// Output-side leaf stage: buffers operator words in a FIFO and wraps each one into a
// 49-bit BFT packet (valid, dest leaf/port, 7-bit seq, payload), re-driving it on resend.
module leaf_stream_packetizer #(
  parameter logic [4:0] DST_LEAF   = 5'd2,
  parameter logic [3:0] DST_PORT   = 4'd0,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ap_start,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        resend,
  output logic [48:0] dout_leaf_interface2bft,
  output logic [15:0] sent_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT
  } state_t;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;

  state_t        r_state;
  state_t        w_nextState;
  logic [6:0]    r_seq;
  logic [6:0]    w_seqUse;
  logic [48:0]   r_packet;
  logic [48:0]   w_packetNext;
  logic [48:0]   r_dout;
  logic [15:0]   r_sentCount;

  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic          w_fifoEmpty;

  assign w_fifoEmpty = (r_count == '0);
  assign din_ready   = (r_count != FULL_COUNT);
  assign w_push      = din_valid && din_ready;

  assign dout_leaf_interface2bft = r_dout;
  assign sent_count              = r_sentCount;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // A packet leaving WAIT without resend is accepted, so a pop on that same edge
  // must already carry the incremented sequence number.
  always_comb begin
    w_nextState  = r_state;
    w_pop        = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifoEmpty && ap_start) begin
          w_pop       = 1'b1;
          w_nextState = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (resend) begin
          w_nextState = ST_EMIT;
        end else begin
          w_accept = 1'b1;
          if (!w_fifoEmpty && ap_start) begin
            w_pop       = 1'b1;
            w_nextState = ST_EMIT;
          end else begin
            w_nextState = ST_IDLE;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    w_seqUse     = w_accept ? (r_seq + 7'd1) : r_seq;
    w_packetNext = w_pop ? {1'b1, DST_LEAF, DST_PORT, w_seqUse, r_mem[r_rdPtr]} : r_packet;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_seq       <= '0;
      r_sentCount <= '0;
      r_packet    <= '0;
      r_dout      <= '0;
    end else begin
      r_state  <= w_nextState;
      r_packet <= w_packetNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept) begin
        r_seq       <= r_seq + 7'd1;
        r_sentCount <= r_sentCount + 16'd1;
      end
      // The port only shows a packet during EMIT; every other state drives zero.
      r_dout <= (w_nextState == ST_EMIT) ? w_packetNext : '0;
    end
  end

endmodule

// File: doc/leaf_stream_packetizer.md
# leaf_stream_packetizer

Output-side stage of a page's leaf interface. It sits between the page operator's 32-bit output stream and the BFT leaf port, and drives the port that the page exposes as `dout_leaf_interface2bft`. Operator words are buffered in a small FIFO and wrapped into 49-bit BFT packets carrying a destination header and a sequence number. Each packet is held for one check cycle, and it is re-driven if the BFT asserts `resend`.

## Interface
- `DST_LEAF`, default 5'd2: destination leaf address placed in header bits [47:43].
- `DST_PORT`, default 4'd0: destination port placed in bits [42:39].
- `FIFO_DEPTH`, default 16: input FIFO entries. Must be a power of two, minimum 2.
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `ap_start`  in  1: enables the start of new packets. Level-sensitive.
- `din`  in  32: operator payload word.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: FIFO can accept; equals `!full`, derived from registered count.
- `resend`  in  1: BFT rejected the packet driven in the previous cycle.
- `dout_leaf_interface2bft`  out  49: packet, registered. All-zero when idle.
- `sent_count`  out  16: number of distinct packets emitted, excluding retries. Wraps at 16'hFFFF.

## Operation
- Packet format: bit 48 = valid (1), [47:43] = `DST_LEAF`, [42:39] = `DST_PORT`, [38:32] = 7-bit seq, [31:0] = payload.
- Push into the FIFO occurs when `din_valid && din_ready`. There is no push when full, and the word is held by the operator.
- The FSM has three states: IDLE, EMIT, WAIT.
  - IDLE: dout = 0. If FIFO non-empty and `ap_start` = 1: pop the head, build the packet with the current seq, go to EMIT.
  - EMIT: dout = packet for exactly one cycle, then go to WAIT.
  - WAIT: dout = 0; sample `resend`.
    - If `resend` = 1: go to EMIT with the identical packet (same seq, same payload).
    - Else increment seq and `sent_count`. Then, if FIFO non-empty and `ap_start` = 1, pop the next entry and go to EMIT; otherwise go to IDLE.
- `resend` is ignored in IDLE and EMIT.
- Seq starts at 0 after reset and increments by 1 per accepted (non-resent) packet. It wraps from 127 to 0.
- Retries are unlimited, and FIFO order is preserved: no later word is emitted until the current one clears WAIT without `resend`.
- `ap_start` deasserted mid-packet: the current EMIT/WAIT/resend sequence completes normally, then the FSM parks in IDLE. Buffered words remain in the FIFO.
- Simultaneous push and pop: both occur and count is unchanged. A push to a full FIFO is blocked even if a pop happens that cycle.
- Reset behaviour:
  - FIFO emptied, state set to IDLE, seq = 0, `sent_count` = 0.
  - From the cycle after the reset edge: dout = 0, and `din_ready` = 1.
  - Reset mid-packet drops the in-flight packet without a retry.

## Timing
- Word accepted at edge k into an empty FIFO, with IDLE and `ap_start` = 1: pop at edge k+1, so dout is valid in cycle k+1..k+2 (one cycle).
- Steady-state throughput is one packet per 2 cycles (EMIT, WAIT alternating).
- A `resend` sampled in WAIT at edge j re-drives the packet in the cycle after edge j.
- `din_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- `sent_count` and seq update at the WAIT-exit edge when `resend` = 0.

## Test plan
- Reset then idle: `reset` = 1 for 2 cycles, then `ap_start` = 1 with no data. Required: dout = 0, `din_ready` = 1, `sent_count` = 0 throughout.
- Single word: push 32'hDEADBEEF with defaults. Required: exactly one cycle of dout = {1'b1, 5'd2, 4'd0, 7'd0, 32'hDEADBEEF}, then zeros, and `sent_count` = 1.
- Resend: push A, B, and hold `resend` = 1 during A's first two WAIT cycles. Required: A emitted 3 times with seq 0, then B once with seq 1, then `sent_count` = 2.
- Backpressure: hold `ap_start` = 0 and push 17 words into the default FIFO. Required: 16 accepted, `din_ready` = 0 after the 16th, and the 17th is held. Raising `ap_start` then drains the FIFO in order at 1 packet per 2 cycles.
- Seq wrap: send 130 packets. Required: seq sequence 0..127, 0, 1, and `sent_count` = 130.
- Mid-operation reset: assert `reset` during EMIT with 5 words buffered. Required: dout = 0 the next cycle, FIFO empty, and the first packet after reset has seq 0 and contains only post-reset data.
